// File: rtl/pkt_len_accum.sv
// pkt_len_accum: totals bytes and flits of each snooped AXI-Stream packet,
// queues one length record per packet and keeps running traffic statistics.
module pkt_len_accum #(
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned FLIT_WIDTH = 12,
  parameter int unsigned STAT_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mon_tvalid,
  input  logic                  mon_tready,
  input  logic                  mon_tlast,
  input  logic [7:0]            bytes_in_flit,
  output logic                  rec_valid,
  input  logic                  rec_ready,
  output logic [LEN_WIDTH-1:0]  rec_bytes,
  output logic [FLIT_WIDTH-1:0] rec_flits,
  output logic                  rec_trunc,
  input  logic                  clear_stats,
  output logic [STAT_WIDTH-1:0] stat_packets,
  output logic [STAT_WIDTH-1:0] stat_bytes,
  output logic [STAT_WIDTH-1:0] stat_dropped,
  output logic [LEN_WIDTH-1:0]  stat_max_len
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned LSUM_W = LEN_WIDTH + 1;
  localparam int unsigned FSUM_W = FLIT_WIDTH + 1;
  localparam int unsigned SSUM_W = STAT_WIDTH + 1;

  typedef enum logic [0:0] {IDLE = 1'b0, IN_PKT = 1'b1} state_t;

  typedef struct packed {
    logic                  trunc;
    logic [FLIT_WIDTH-1:0] flits;
    logic [LEN_WIDTH-1:0]  bytes;
  } rec_t;

  state_t                state;
  logic                  beat_d;
  logic                  last_d;
  logic [LEN_WIDTH-1:0]  acc_bytes;
  logic [FLIT_WIDTH-1:0] acc_flits;
  logic                  acc_trunc;

  logic [LSUM_W-1:0]     byte_sum_c;
  logic [FSUM_W-1:0]     flit_sum_c;
  rec_t                  new_rec_c;
  logic                  emit_c;

  rec_t                  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_nxt_c;
  logic                  full_c;
  logic                  pop_c;
  logic                  push_c;
  logic                  drop_c;
  rec_t                  head_c;

  logic [SSUM_W-1:0]     pkt_sum_c;
  logic [SSUM_W-1:0]     byte_tot_c;
  logic [SSUM_W-1:0]     drop_sum_c;

  // Align the handshake with the byte count, which arrives one cycle late.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_d <= 1'b0;
      last_d <= 1'b0;
    end else begin
      beat_d <= mon_tvalid & mon_tready;
      last_d <= mon_tlast;
    end
  end

  // Saturating running sums including the current flit; this is the record when last_d.
  always_comb begin
    byte_sum_c      = {1'b0, acc_bytes} + LSUM_W'(bytes_in_flit);
    flit_sum_c      = {1'b0, acc_flits} + FSUM_W'(1);
    new_rec_c       = '0;
    new_rec_c.bytes = byte_sum_c[LEN_WIDTH] ? '1 : byte_sum_c[LEN_WIDTH-1:0];
    new_rec_c.flits = flit_sum_c[FLIT_WIDTH] ? '1 : flit_sum_c[FLIT_WIDTH-1:0];
    new_rec_c.trunc = acc_trunc | byte_sum_c[LEN_WIDTH] | flit_sum_c[FLIT_WIDTH];
    emit_c          = beat_d & last_d;
  end

  // Packet framing FSM and per-packet accumulators.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc_bytes <= '0;
      acc_flits <= '0;
      acc_trunc <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (beat_d && !last_d) begin
            state     <= IN_PKT;
            acc_bytes <= new_rec_c.bytes;
            acc_flits <= new_rec_c.flits;
            acc_trunc <= new_rec_c.trunc;
          end
        end
        IN_PKT: begin
          if (beat_d) begin
            if (last_d) begin
              state     <= IDLE;
              acc_bytes <= '0;
              acc_flits <= '0;
              acc_trunc <= 1'b0;
            end else begin
              acc_bytes <= new_rec_c.bytes;
              acc_flits <= new_rec_c.flits;
              acc_trunc <= new_rec_c.trunc;
            end
          end
        end
        default: begin
          state     <= IDLE;
          acc_bytes <= '0;
          acc_flits <= '0;
          acc_trunc <= 1'b0;
        end
      endcase
    end
  end

  // Record FIFO control: a full FIFO still accepts a push when the head pops.
  always_comb begin
    full_c      = (count == CNT_W'(FIFO_DEPTH));
    pop_c       = rec_valid & rec_ready;
    push_c      = emit_c & (!full_c | pop_c);
    drop_c      = emit_c & !push_c;
    count_nxt_c = count + CNT_W'(push_c) - CNT_W'(pop_c);
  end

  // Record FIFO storage and pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem[i] <= '0;
      end
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rec_valid <= 1'b0;
    end else begin
      if (push_c) begin
        mem[wr_ptr] <= new_rec_c;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count     <= count_nxt_c;
      rec_valid <= (count_nxt_c != '0);
    end
  end

  assign head_c    = mem[rd_ptr];
  assign rec_bytes = head_c.bytes;
  assign rec_flits = head_c.flits;
  assign rec_trunc = head_c.trunc;

  // Saturating statistics sums.
  always_comb begin
    pkt_sum_c  = {1'b0, stat_packets} + SSUM_W'(1);
    byte_tot_c = {1'b0, stat_bytes} + SSUM_W'(new_rec_c.bytes);
    drop_sum_c = {1'b0, stat_dropped} + SSUM_W'(1);
  end

  // Statistics: one update per emitted record; clear_stats wins over that update.
  always_ff @(posedge clk) begin
    if (reset || clear_stats) begin
      stat_packets <= '0;
      stat_bytes   <= '0;
      stat_dropped <= '0;
      stat_max_len <= '0;
    end else if (emit_c) begin
      stat_packets <= pkt_sum_c[STAT_WIDTH] ? '1 : pkt_sum_c[STAT_WIDTH-1:0];
      stat_bytes   <= byte_tot_c[STAT_WIDTH] ? '1 : byte_tot_c[STAT_WIDTH-1:0];
      if (drop_c) begin
        stat_dropped <= drop_sum_c[STAT_WIDTH] ? '1 : drop_sum_c[STAT_WIDTH-1:0];
      end
      if (new_rec_c.bytes > stat_max_len) begin
        stat_max_len <= new_rec_c.bytes;
      end
    end
  end

endmodule

// File: tb/tb_pkt_len_accum.sv
// tb_pkt_len_accum: directed plus randomized stimulus checked against a
// packet-level reference model (unbounded totals clamped at record time).
module tb_pkt_len_accum;

  localparam int unsigned LW = 8;
  localparam int unsigned FW = 6;
  localparam int unsigned SW = 12;
  localparam int unsigned DEPTH = 4;
  localparam int LMAX = (1 << LW) - 1;
  localparam int FMAX = (1 << FW) - 1;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          mon_tvalid;
  logic          mon_tready;
  logic          mon_tlast;
  logic [7:0]    bytes_in_flit;
  logic          rec_valid;
  logic          rec_ready;
  logic [LW-1:0] rec_bytes;
  logic [FW-1:0] rec_flits;
  logic          rec_trunc;
  logic          clear_stats;
  logic [SW-1:0] stat_packets;
  logic [SW-1:0] stat_bytes;
  logic [SW-1:0] stat_dropped;
  logic [LW-1:0] stat_max_len;

  pkt_len_accum #(
    .LEN_WIDTH (LW),
    .FLIT_WIDTH(FW),
    .STAT_WIDTH(SW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mon_tvalid   (mon_tvalid),
    .mon_tready   (mon_tready),
    .mon_tlast    (mon_tlast),
    .bytes_in_flit(bytes_in_flit),
    .rec_valid    (rec_valid),
    .rec_ready    (rec_ready),
    .rec_bytes    (rec_bytes),
    .rec_flits    (rec_flits),
    .rec_trunc    (rec_trunc),
    .clear_stats  (clear_stats),
    .stat_packets (stat_packets),
    .stat_bytes   (stat_bytes),
    .stat_dropped (stat_dropped),
    .stat_max_len (stat_max_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    int bytes;
    int flits;
    bit trunc;
  } rec_m_t;

  int     checks = 0;
  int     errors = 0;

  // Reference model state
  rec_m_t q[$];
  int     pk_bytes = 0;
  int     pk_flits = 0;
  int     s_pk = 0;
  int     s_by = 0;
  int     s_dr = 0;
  int     s_mx = 0;
  bit     pend_beat = 1'b0;
  bit     pend_last = 1'b0;
  int     nxt_bif = 0;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare just after it.
  task automatic cycle(input bit rst, input bit v, input bit trd, input bit last,
                       input int cnt, input bit rr, input bit clr);
    rec_m_t r;
    bit     emit;
    int     bif_cur;
    bif_cur       = nxt_bif;
    reset         = rst;
    mon_tvalid    = v;
    mon_tready    = trd;
    mon_tlast     = last;
    bytes_in_flit = 8'(bif_cur);
    rec_ready     = rr;
    clear_stats   = clr;
    @(posedge clk);
    emit = 1'b0;
    r    = '{0, 0, 1'b0};
    if (rst) begin
      q.delete();
      pk_bytes = 0;
      pk_flits = 0;
      s_pk = 0; s_by = 0; s_dr = 0; s_mx = 0;
    end else begin
      if (pend_beat) begin
        pk_bytes += bif_cur;
        pk_flits += 1;
        if (pend_last) begin
          r.bytes  = sat(pk_bytes, LMAX);
          r.flits  = sat(pk_flits, FMAX);
          r.trunc  = (pk_bytes > LMAX) || (pk_flits > FMAX);
          emit     = 1'b1;
          pk_bytes = 0;
          pk_flits = 0;
        end
      end
      if (q.size() > 0 && rr) void'(q.pop_front());
      if (clr) begin
        s_pk = 0; s_by = 0; s_dr = 0; s_mx = 0;
      end else if (emit) begin
        s_pk = sat(s_pk + 1, SMAX);
        s_by = sat(s_by + r.bytes, SMAX);
        if (q.size() >= DEPTH) s_dr = sat(s_dr + 1, SMAX);
        if (r.bytes > s_mx) s_mx = r.bytes;
      end
      if (emit && q.size() < DEPTH) q.push_back(r);
    end
    pend_beat = v & trd & !rst;
    pend_last = last;
    nxt_bif   = pend_beat ? cnt : int'($urandom_range(0, 255));
    #1;
    chk("rec_valid", 32'(rec_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("rec_bytes", 32'(rec_bytes), 32'(q[0].bytes));
      chk("rec_flits", 32'(rec_flits), 32'(q[0].flits));
      chk("rec_trunc", 32'(rec_trunc), 32'(q[0].trunc));
    end else if (rst) begin
      chk("rst_rec_bytes", 32'(rec_bytes), 32'd0);
      chk("rst_rec_flits", 32'(rec_flits), 32'd0);
      chk("rst_rec_trunc", 32'(rec_trunc), 32'd0);
    end
    chk("stat_packets", 32'(stat_packets), 32'(s_pk));
    chk("stat_bytes", 32'(stat_bytes), 32'(s_by));
    chk("stat_dropped", 32'(stat_dropped), 32'(s_dr));
    chk("stat_max_len", 32'(stat_max_len), 32'(s_mx));
  endtask

  task automatic beat(input bit last, input int cnt, input bit rr);
    cycle(1'b0, 1'b1, 1'b1, last, cnt, rr, 1'b0);
  endtask

  task automatic idle(input bit rr);
    cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, rr, 1'b0);
  endtask

  task automatic clr_cycle();
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b1);
  endtask

  initial begin
    // Reset
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    idle(1'b0);

    // Three-flit packet 8,8,4: record visible two cycles after the tlast beat
    beat(1'b0, 8, 1'b0);
    beat(1'b0, 8, 1'b0);
    beat(1'b1, 4, 1'b0);
    chk("tp1_not_yet", 32'(rec_valid), 32'd0);
    idle(1'b0);
    chk("tp1_valid", 32'(rec_valid), 32'd1);
    chk("tp1_bytes", 32'(rec_bytes), 32'd20);
    chk("tp1_flits", 32'(rec_flits), 32'd3);
    chk("tp1_trunc", 32'(rec_trunc), 32'd0);
    chk("tp1_pkts", 32'(stat_packets), 32'd1);
    chk("tp1_sbytes", 32'(stat_bytes), 32'd20);
    chk("tp1_max", 32'(stat_max_len), 32'd20);
    idle(1'b1);

    // Back-to-back single-flit packets
    clr_cycle();
    beat(1'b1, 8, 1'b0);
    beat(1'b1, 1, 1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("tp2_pkts", 32'(stat_packets), 32'd2);
    chk("tp2_sbytes", 32'(stat_bytes), 32'd9);
    chk("tp2_head", 32'(rec_bytes), 32'd8);
    idle(1'b1);
    chk("tp2_head2", 32'(rec_bytes), 32'd1);
    idle(1'b1);

    // Full FIFO drops the fifth record
    clr_cycle();
    for (int i = 0; i < 5; i++) beat(1'b1, 5, 1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("tp3_dropped", 32'(stat_dropped), 32'd1);
    chk("tp3_pkts", 32'(stat_packets), 32'd5);
    for (int i = 0; i < 5; i++) idle(1'b1);
    chk("tp3_empty", 32'(rec_valid), 32'd0);

    // Byte saturation, then a clean packet
    clr_cycle();
    for (int i = 0; i < 39; i++) beat(1'b0, 8, 1'b0);
    beat(1'b1, 8, 1'b0);
    idle(1'b0);
    chk("tp4_bytes", 32'(rec_bytes), 32'd255);
    chk("tp4_flits", 32'(rec_flits), 32'd40);
    chk("tp4_trunc", 32'(rec_trunc), 32'd1);
    idle(1'b1);
    beat(1'b1, 8, 1'b0);
    idle(1'b0);
    chk("tp4_next_trunc", 32'(rec_trunc), 32'd0);
    chk("tp4_next_bytes", 32'(rec_bytes), 32'd8);
    idle(1'b1);

    // Flit saturation with zero-byte flits
    for (int i = 0; i < 69; i++) beat(1'b0, 0, 1'b1);
    beat(1'b1, 0, 1'b1);
    idle(1'b0);
    chk("flitsat_flits", 32'(rec_flits), 32'd63);
    chk("flitsat_trunc", 32'(rec_trunc), 32'd1);
    idle(1'b1);

    // Reset mid-packet
    beat(1'b0, 8, 1'b0);
    beat(1'b0, 8, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    chk("tp5_rst_valid", 32'(rec_valid), 32'd0);
    beat(1'b1, 4, 1'b0);
    idle(1'b0);
    chk("tp5_bytes", 32'(rec_bytes), 32'd4);
    chk("tp5_flits", 32'(rec_flits), 32'd1);
    chk("tp5_pkts", 32'(stat_packets), 32'd1);
    idle(1'b1);

    // clear_stats in the record-forming cycle
    beat(1'b1, 16, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    chk("tp6_pkts", 32'(stat_packets), 32'd0);
    chk("tp6_sbytes", 32'(stat_bytes), 32'd0);
    chk("tp6_valid", 32'(rec_valid), 32'd1);
    chk("tp6_bytes", 32'(rec_bytes), 32'd16);
    idle(1'b1);

    // Statistics saturation
    clr_cycle();
    for (int i = 0; i < 17; i++) beat(1'b1, 255, 1'b1);
    idle(1'b1);
    chk("ssat_bytes", 32'(stat_bytes), 32'd4095);
    chk("ssat_pkts", 32'(stat_packets), 32'd17);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cycle(1'($urandom_range(0, 199) == 0),
            1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 4) == 0),
            int'($urandom_range(0, 64)),
            1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 99) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pkt_len_accum.md
# pkt_len_accum

Per-packet length accumulator for the packet snooper, directly downstream of the tkeep-to-byte-count stage. It consumes that stage's registered per-flit byte count together with the snooped AXI-Stream handshake. It then:
- totals bytes and flits per packet (delimited by tlast),
- pushes one length record per packet into a small output FIFO with a valid/ready interface,
- maintains running packet statistics for the traffic monitor.

## Interface
- LEN_WIDTH, 16, width of per-packet byte count (saturating)
- FLIT_WIDTH, 12, width of per-packet flit count (saturating)
- STAT_WIDTH, 32, width of statistics counters (saturating)
- FIFO_DEPTH, 4, record FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- mon_tvalid  in  1  snooped tvalid (same cycle as keep fed to upstream stage)
- mon_tready  in  1  snooped tready
- mon_tlast  in  1  snooped tlast
- bytes_in_flit  in  8  byte count from upstream stage, valid one cycle after the beat
- rec_valid  out  1  record available at FIFO head
- rec_ready  in  1  consumer accepts head record
- rec_bytes  out  LEN_WIDTH  packet byte total
- rec_flits  out  FLIT_WIDTH  packet flit total
- rec_trunc  out  1  byte or flit count saturated in this packet
- clear_stats  in  1  single-cycle pulse, zeroes statistics
- stat_packets  out  STAT_WIDTH  records produced (including dropped)
- stat_bytes  out  STAT_WIDTH  sum of rec_bytes produced
- stat_dropped  out  STAT_WIDTH  records lost to full FIFO
- stat_max_len  out  LEN_WIDTH  largest rec_bytes since clear

## Operation
- Beat = mon_tvalid & mon_tready. Register beat and mon_tlast into beat_d and last_d, aligned with bytes_in_flit.
- FSM has two states:
  - IDLE: accumulators zero. beat_d & !last_d → IN_PKT. beat_d & last_d → single-flit record, stay in IDLE.
  - IN_PKT: each beat_d adds bytes_in_flit to acc_bytes and increments acc_flits. beat_d & last_d → emit record, clear accumulators, go to IDLE.
- Record values are the final sum including the last flit.
- A zero-byte flit still counts as a flit.
- Saturation: a sum exceeding 2^LEN_WIDTH−1 clamps to that value and sets a sticky trunc flag for the packet. The flit count behaves the same way.
- Records are pushed into the FIFO in order.
  - Push succeeds when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Otherwise the record is discarded and stat_dropped increments.
- rec_* shows the FIFO head. A pop occurs on rec_valid & rec_ready.
- Statistics update once per emitted record, whether or not it was dropped. All statistics counters saturate.
- clear_stats has priority over a same-cycle record: statistics become 0, and that record's contribution is lost. The record is still pushed to the FIFO.
- Reset mid-packet:
  - Accumulators, beat_d, FIFO and statistics clear.
  - Post-reset beats up to the next tlast form one record containing only post-reset beats.
  - There is no resynchronisation.

## Timing
- Reset values:
  - rec_valid=0, rec_bytes=0, rec_flits=0, rec_trunc=0
  - all stat_* = 0
  - FSM in IDLE, FIFO empty
- Latency: a tlast beat at cycle N reaches the record-forming logic at N+1. rec_valid and the updated stat_* are visible at N+2 when the FIFO was empty.
- Back-to-back packets are handled without bubbles: tlast at N and a new packet's first beat at N+1 produce separate records.
- The block never backpressures the monitored link. Throughput is one flit per cycle.
- rec_* stay stable while rec_valid & !rec_ready.

## Test plan
- Three-flit packet, upstream counts 8, 8, 4 with tlast on the third flit at cycle N → rec_valid at N+2, rec_bytes=20, rec_flits=3, rec_trunc=0, stat_packets=1, stat_bytes=20, stat_max_len=20.
- Consecutive single-flit packets with tlast every cycle and counts 8, 1 → two records (8,1) and (1,1), stat_packets=2, stat_bytes=9.
- rec_ready=0, FIFO_DEPTH=4, five packets of 5 bytes each → 4 records held, stat_dropped=1, stat_packets=5. Then rec_ready=1 drains four 5-byte records in order.
- LEN_WIDTH=8, one packet of 40 flits × 8 bytes → rec_bytes=255, rec_flits=40, rec_trunc=1. The following 8-byte packet has rec_trunc=0.
- Reset after 2 beats of a packet, then one beat with tlast and count 4 → all outputs 0 during reset, then record (4,1), stat_packets=1.
- clear_stats asserted in the cycle a 16-byte record is formed → stat_* all 0 next cycle, record (16,·) still delivered on rec_*.
